// File: rtl/alg1_dispatch_if.sv
// Bus bundle between the Alg1 dispatcher and its producer, Alg1 engine and result consumer.
// res_err_o exists only when ALG1_DISPATCH_TIMEOUT_EN is defined.
interface alg1_dispatch_if #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned DEPTH    = 4
);
  localparam int unsigned W  = BITWIDTH + 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  in_a_i;
  logic [W-1:0]  in_b_i;
  logic          alg_start_o;
  logic [W-1:0]  alg_a_o;
  logic [W-1:0]  alg_b_o;
  logic          alg_done_i;
  logic [W-1:0]  alg_y_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [W-1:0]  res_y_o;
  logic          busy_o;
  logic [CW-1:0] count_o;
`ifdef ALG1_DISPATCH_TIMEOUT_EN
  logic          res_err_o;
`endif

  // Dispatcher side
  modport slave (
    input  in_valid_i, in_a_i, in_b_i, alg_done_i, alg_y_i, res_ready_i,
    output in_ready_o, alg_start_o, alg_a_o, alg_b_o, res_valid_o, res_y_o,
`ifdef ALG1_DISPATCH_TIMEOUT_EN
    output res_err_o,
`endif
    output busy_o, count_o
  );

  // Environment side: producer, Alg1 instance and result consumer
  modport master (
    output in_valid_i, in_a_i, in_b_i, alg_done_i, alg_y_i, res_ready_i,
    input  in_ready_o, alg_start_o, alg_a_o, alg_b_o, res_valid_o, res_y_o,
`ifdef ALG1_DISPATCH_TIMEOUT_EN
    input  res_err_o,
`endif
    input  busy_o, count_o
  );
endinterface

// File: rtl/alg1_dispatch.sv
// Operand FIFO plus start/done sequencer feeding one Alg1 engine, one transaction at a time.
// Optional ISSUE watchdog enabled by defining ALG1_DISPATCH_TIMEOUT_EN.
module alg1_dispatch #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input logic           CLK,
  input logic           RST,
  alg1_dispatch_if.slave bus
);
  localparam int unsigned W  = BITWIDTH + 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_bad_cfg
    $error("alg1_dispatch: DEPTH must be a power of two >= 2 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, OUT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem_a [DEPTH];
  logic [W-1:0]  mem_b [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q;
  logic          start_q, res_valid_q, busy_q;
  logic [W-1:0]  a_q, b_q, res_y_q;
  logic          push, pop, capture;

`ifdef ALG1_DISPATCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          expire;
  logic          res_err_q;
`endif

  assign push = bus.in_valid_i & in_ready_q;

  // Next-state decode; pop only on the IDLE->ISSUE hop
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
`ifdef ALG1_DISPATCH_TIMEOUT_EN
    wd_d    = wd_q;
    expire  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != '0 && !bus.alg_done_i) begin
          pop     = 1'b1;
          state_d = ISSUE;
`ifdef ALG1_DISPATCH_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      ISSUE: begin
        if (bus.alg_done_i) begin
          capture = 1'b1;
          state_d = RELEASE;
        end
`ifdef ALG1_DISPATCH_TIMEOUT_EN
        else if (wd_q == TW'(TIMEOUT - 1)) begin
          expire  = 1'b1;
          state_d = RELEASE;
        end else begin
          wd_d = wd_q + TW'(1);
        end
`endif
      end
      RELEASE: if (!bus.alg_done_i) state_d = OUT;
      OUT:     if (bus.res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Payload storage is not reset; pointers and count define validity
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_a[wr_ptr_q] <= bus.in_a_i;
      mem_b[wr_ptr_q] <= bus.in_b_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_ready_q  <= (count_d != CW'(DEPTH));
      start_q     <= (state_d == ISSUE);
      res_valid_q <= (state_d == OUT);
      busy_q      <= (state_d != IDLE);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        a_q      <= mem_a[rd_ptr_q];
        b_q      <= mem_b[rd_ptr_q];
      end
      if (capture) res_y_q <= bus.alg_y_i;
`ifdef ALG1_DISPATCH_TIMEOUT_EN
      if (expire) res_y_q <= '0;
`endif
    end
  end

`ifdef ALG1_DISPATCH_TIMEOUT_EN
  // Watchdog count and sticky error flag, cleared by the result handshake
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_q      <= '0;
      res_err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (expire)                                res_err_q <= 1'b1;
      else if (capture)                          res_err_q <= 1'b0;
      else if (state_q == OUT && bus.res_ready_i) res_err_q <= 1'b0;
    end
  end
  assign bus.res_err_o = res_err_q;
`endif

  assign bus.in_ready_o  = in_ready_q;
  assign bus.alg_start_o = start_q;
  assign bus.alg_a_o     = a_q;
  assign bus.alg_b_o     = b_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_y_o     = res_y_q;
  assign bus.busy_o      = busy_q;
  assign bus.count_o     = count_q;
endmodule

// File: tb/tb_alg1_dispatch.sv
// Bench for alg1_dispatch: directed scenarios plus random traffic against a queue-based reference.
// A behavioural Alg1 responder drives done/y; the result function is y = a*b + 27.
module tb_alg1_dispatch;
  localparam int unsigned BITWIDTH = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TIMEOUT  = 8;
  localparam int unsigned W        = BITWIDTH + 1;

  logic CLK, RST;
  alg1_dispatch_if #(.BITWIDTH(BITWIDTH), .DEPTH(DEPTH)) bus ();

  alg1_dispatch #(.BITWIDTH(BITWIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] alg_fn(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = a * b + W'(27);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Alg1 behavioural responder controls
  bit alg_never = 0;
  bit lat_rand  = 0;
  bit expect_to = 0;
  int alg_lat   = 12;
  int alg_hold  = 0;

  initial begin
    int  cnt, cur_lat, hold;
    bit  r_busy;
    cnt = 0; cur_lat = 1; hold = 0; r_busy = 0;
    bus.alg_done_i = 1'b0;
    bus.alg_y_i    = '0;
    forever begin
      @(posedge CLK); #1;
      if (!r_busy) begin
        if (bus.alg_start_o === 1'b1) begin
          cnt++;
          if (cnt == 1) cur_lat = lat_rand ? int'($urandom_range(1, 6)) : alg_lat;
          if (!alg_never && cnt >= cur_lat) begin
            bus.alg_done_i = 1'b1;
            bus.alg_y_i    = alg_fn(bus.alg_a_o, bus.alg_b_o);
            hold   = lat_rand ? int'($urandom_range(0, 2)) : alg_hold;
            r_busy = 1;
          end
        end else begin
          cnt = 0;
        end
      end else if (bus.alg_start_o === 1'b0) begin
        if (hold == 0) begin
          bus.alg_done_i = 1'b0;
          r_busy = 0;
          cnt    = 0;
        end else begin
          hold--;
        end
      end
    end
  end

  // Reference model: queued operand pairs and expected results in order
  logic [W-1:0] pa_q[$], pb_q[$], ey_q[$];
  bit           ee_q[$];
  bit           inflight = 0;

  task automatic step();
    bit           rst_b, pushed, hs, prev_start;
    logic [W-1:0] a_b, b_b, y_b;
    logic [W-1:0] ea, eb, ey;
    bit           ee;
    bit           err_b;
    rst_b      = (RST === 1'b1);
    pushed     = (bus.in_valid_i === 1'b1) && (bus.in_ready_o === 1'b1);
    hs         = (bus.res_valid_o === 1'b1) && (bus.res_ready_i === 1'b1);
    a_b        = bus.in_a_i;
    b_b        = bus.in_b_i;
    y_b        = bus.res_y_o;
    prev_start = (bus.alg_start_o === 1'b1);
    err_b      = 1'b0;
`ifdef ALG1_DISPATCH_TIMEOUT_EN
    err_b      = bus.res_err_o;
`endif
    @(posedge CLK); #1;
    if (rst_b) begin
      pa_q.delete(); pb_q.delete(); ey_q.delete(); ee_q.delete();
      inflight = 0;
    end else begin
      if (hs) begin
        chk("result_expected", 64'(ey_q.size() != 0), 64'(1));
        if (ey_q.size() != 0) begin
          ey = ey_q.pop_front();
          ee = ee_q.pop_front();
          chk("result_y", 64'(y_b), 64'(ey));
`ifdef ALG1_DISPATCH_TIMEOUT_EN
          chk("result_err", 64'(err_b), 64'(ee));
`else
          if (ee) chk("result_err_unused", 64'(err_b), 64'(0));
`endif
        end
        inflight = 0;
      end
      if (bus.alg_start_o === 1'b1 && !prev_start) begin
        chk("issue_nonempty", 64'(pa_q.size() != 0), 64'(1));
        if (pa_q.size() != 0) begin
          ea = pa_q.pop_front();
          eb = pb_q.pop_front();
          chk("issue_a", 64'(bus.alg_a_o), 64'(ea));
          chk("issue_b", 64'(bus.alg_b_o), 64'(eb));
          ey_q.push_back(expect_to ? '0 : alg_fn(ea, eb));
          ee_q.push_back(expect_to);
        end
        inflight = 1;
      end
      if (pushed) begin
        pa_q.push_back(a_b);
        pb_q.push_back(b_b);
      end
    end
    chk("count", 64'(bus.count_o), 64'(pa_q.size()));
    chk("in_ready", 64'(bus.in_ready_o), 64'(pa_q.size() != DEPTH));
    chk("busy", 64'(bus.busy_o), 64'(inflight));
  endtask

  task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid_i = 1'b1;
    bus.in_a_i     = a;
    bus.in_b_i     = b;
    step();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.in_valid_i  = 1'b0;
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 500 && (pa_q.size() != 0 || ey_q.size() != 0 || bus.busy_o === 1'b1); i++) step();
    chk(tag, 64'(pa_q.size() + ey_q.size()), 64'(0));
  endtask

  initial begin
    logic [W-1:0] y_snap;
    logic [3:0]   c_snap;
    int           n;
    RST = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.in_a_i      = '0;
    bus.in_b_i      = '0;
    bus.res_ready_i = 1'b1;
    step(); step();
    RST = 1'b0;
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'(1));
    chk("rst_start", 64'(bus.alg_start_o), 64'(0));
    chk("rst_a", 64'(bus.alg_a_o), 64'(0));
    chk("rst_b", 64'(bus.alg_b_o), 64'(0));
    chk("rst_valid", 64'(bus.res_valid_o), 64'(0));
    chk("rst_y", 64'(bus.res_y_o), 64'(0));
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    chk("rst_count", 64'(bus.count_o), 64'(0));

    // Single transaction, done after 12 start cycles
    push_one(W'(5), W'(3));
    chk("t1_start_k", 64'(bus.alg_start_o), 64'(0));
    step();
    chk("t1_start_k1", 64'(bus.alg_start_o), 64'(1));
    chk("t1_a", 64'(bus.alg_a_o), 64'(5));
    chk("t1_b", 64'(bus.alg_b_o), 64'(3));
    for (int i = 0; i < 40 && bus.res_valid_o !== 1'b1; i++) begin
      step();
      chk("t1_a_hold", 64'(bus.alg_a_o), 64'(5));
      chk("t1_b_hold", 64'(bus.alg_b_o), 64'(3));
    end
    chk("t1_valid", 64'(bus.res_valid_o), 64'(1));
    chk("t1_y", 64'(bus.res_y_o), 64'h2A);
    chk("t1_start_off", 64'(bus.alg_start_o), 64'(0));
    step();
    chk("t1_valid_once", 64'(bus.res_valid_o), 64'(0));
    chk("t1_idle", 64'(bus.busy_o), 64'(0));

    // FIFO fill with engine stalled
    alg_never = 1;
    for (int i = 0; i < 6; i++) begin
      chk("t2_ready", 64'(bus.in_ready_o), 64'(i < 5));
      push_one(rand_w(), rand_w());
    end
    chk("t2_count_full", 64'(bus.count_o), 64'(4));
    chk("t2_ready_full", 64'(bus.in_ready_o), 64'(0));
    alg_never = 0;
    alg_lat   = 3;
    drain("t2_drain");

    // Result backpressure
    bus.res_ready_i = 1'b0;
    push_one(rand_w(), rand_w());
    for (int i = 0; i < 40 && bus.res_valid_o !== 1'b1; i++) step();
    chk("t3_valid", 64'(bus.res_valid_o), 64'(1));
    y_snap = bus.res_y_o;
    c_snap = 4'(bus.count_o);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_valid_hold", 64'(bus.res_valid_o), 64'(1));
      chk("t3_y_hold", 64'(bus.res_y_o), 64'(y_snap));
      chk("t3_start", 64'(bus.alg_start_o), 64'(0));
      chk("t3_count", 64'(bus.count_o), 64'(c_snap));
    end
    bus.res_ready_i = 1'b1;
    step();
    chk("t3_idle", 64'(bus.busy_o), 64'(0));
    chk("t3_valid_clr", 64'(bus.res_valid_o), 64'(0));

    // Done held high after start drops
    alg_hold = 3;
    push_one(rand_w(), rand_w());
    push_one(rand_w(), rand_w());
    for (int i = 0; i < 40 && bus.alg_start_o !== 1'b1; i++) step();
    for (int i = 0; i < 40 && bus.alg_start_o === 1'b1; i++) step();
    chk("t4_start_dropped", 64'(bus.alg_start_o), 64'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_no_start", 64'(bus.alg_start_o), 64'(0));
      chk("t4_no_valid", 64'(bus.res_valid_o), 64'(0));
      chk("t4_busy", 64'(bus.busy_o), 64'(1));
    end
    alg_hold = 0;
    drain("t4_drain");

    // Reset while issuing with two entries queued
    alg_never = 1;
    push_one(rand_w(), rand_w());
    push_one(rand_w(), rand_w());
    push_one(rand_w(), rand_w());
    chk("t5_count", 64'(bus.count_o), 64'(2));
    chk("t5_issuing", 64'(bus.alg_start_o), 64'(1));
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t5_start", 64'(bus.alg_start_o), 64'(0));
    chk("t5_valid", 64'(bus.res_valid_o), 64'(0));
    chk("t5_count0", 64'(bus.count_o), 64'(0));
    chk("t5_ready", 64'(bus.in_ready_o), 64'(1));
    chk("t5_busy", 64'(bus.busy_o), 64'(0));
    alg_never = 0;
    step();

`ifdef ALG1_DISPATCH_TIMEOUT_EN
    // Watchdog abort
    alg_never = 1;
    expect_to = 1;
    push_one(rand_w(), rand_w());
    for (int i = 0; i < 10 && bus.alg_start_o !== 1'b1; i++) step();
    n = 0;
    while (bus.alg_start_o === 1'b1 && n < 50) begin
      n++;
      step();
    end
    chk("t6_issue_cycles", 64'(n), 64'(TIMEOUT));
    for (int i = 0; i < 10 && bus.res_valid_o !== 1'b1; i++) step();
    chk("t6_valid", 64'(bus.res_valid_o), 64'(1));
    chk("t6_err", 64'(bus.res_err_o), 64'(1));
    chk("t6_y", 64'(bus.res_y_o), 64'(0));
    step();
    chk("t6_err_clr", 64'(bus.res_err_o), 64'(0));
    expect_to = 0;
    alg_never = 0;
`else
    n = 0;
`endif

    // Random traffic
    lat_rand = 1;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid_i  = 1'($urandom_range(0, 1));
      bus.in_a_i      = rand_w();
      bus.in_b_i      = rand_w();
      bus.res_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand_drain");
    chk("final_idle", 64'(bus.busy_o), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
